// File: rtl/disp_vertical_averager_if.sv
// Stream bundle between the pixel processing stage and the vertical averager:
// decimated disp*conf / conf samples in, per-block weighted means out.
interface disp_vertical_averager_if #(
    parameter int disp_bits = 5
);
    logic                   frame_start;
    logic [disp_bits+7:0]   disp_conf_in;
    logic [7:0]             conf_in;
    logic                   in_valid;
    logic [disp_bits-1:0]   disp_out;
    logic [7:0]             conf_out;
    logic                   out_valid;

    modport master (
        output frame_start, disp_conf_in, conf_in, in_valid,
        input  disp_out, conf_out, out_valid
    );

    modport slave (
        input  frame_start, disp_conf_in, conf_in, in_valid,
        output disp_out, conf_out, out_valid
    );
endinterface

// File: rtl/disp_vertical_averager.sv
// Accumulates dec_factor rows of disp*conf and conf per column in a line buffer,
// then divides the two sums in a pipelined restoring divider.
module disp_vertical_averager #(
    parameter int disp_bits  = 5,
    parameter int dec_factor = 2,
    parameter int out_width  = 320
) (
    input  logic                      clk,
    input  logic                      reset,
    disp_vertical_averager_if.slave   bus
);
    localparam int LOG2_DEC = $clog2(dec_factor);
    localparam int COL_W    = $clog2(out_width);
    localparam int ROW_W    = (LOG2_DEC < 1) ? 1 : LOG2_DEC;
    localparam int DC_W     = disp_bits + 8;
    localparam int SDC_W    = DC_W + LOG2_DEC;
    localparam int SC_W     = 8 + LOG2_DEC;
    localparam int ENT_W    = SDC_W + SC_W;

    // ---------------- position counters ----------------
    logic [COL_W-1:0] r_col, w_col_cur, w_col_next;
    logic [ROW_W-1:0] r_row, w_row_cur, w_row_next;

    always_comb begin
        w_col_cur  = bus.frame_start ? '0 : r_col;
        w_row_cur  = bus.frame_start ? '0 : r_row;
        w_col_next = w_col_cur + COL_W'(1);
        w_row_next = w_row_cur;
        if (w_col_cur == COL_W'(out_width - 1)) begin
            w_col_next = '0;
            w_row_next = (w_row_cur == ROW_W'(dec_factor - 1)) ? '0 : w_row_cur + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.in_valid) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
        end else if (bus.frame_start) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    // ---------------- stage 0: capture sample and position ----------------
    logic             r_s0_valid, r_s0_first, r_s0_last;
    logic [COL_W-1:0] r_s0_col;
    logic [DC_W-1:0]  r_s0_dc;
    logic [7:0]       r_s0_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_valid <= 1'b0;
            r_s0_first <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s0_col   <= '0;
            r_s0_dc    <= '0;
            r_s0_c     <= '0;
        end else begin
            r_s0_valid <= bus.in_valid;
            r_s0_first <= (w_row_cur == '0);
            r_s0_last  <= (w_row_cur == ROW_W'(dec_factor - 1));
            r_s0_col   <= w_col_cur;
            r_s0_dc    <= bus.disp_conf_in;
            r_s0_c     <= bus.conf_in;
        end
    end

    // ---------------- stage 1: line buffer read ----------------
    logic             r_s1_valid, r_s1_first, r_s1_last;
    logic [COL_W-1:0] r_s1_col;
    logic [DC_W-1:0]  r_s1_dc;
    logic [7:0]       r_s1_c;
    logic [ENT_W-1:0] r_ram [0:out_width-1];
    logic [ENT_W-1:0] r_rd_data;
    logic             w_wr_en;
    logic [ENT_W-1:0] w_wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_col   <= '0;
            r_s1_dc    <= '0;
            r_s1_c     <= '0;
        end else begin
            r_s1_valid <= r_s0_valid;
            r_s1_first <= r_s0_first;
            r_s1_last  <= r_s0_last;
            r_s1_col   <= r_s0_col;
            r_s1_dc    <= r_s0_dc;
            r_s1_c     <= r_s0_c;
        end
    end

    // Same-address read and write are always at least two edges apart, so plain
    // read-before-write RAM semantics are enough.
    always_ff @(posedge clk) begin
        if (r_s0_valid)
            r_rd_data <= r_ram[r_s0_col];
        if (w_wr_en)
            r_ram[r_s1_col] <= w_wr_data;
    end

    // ---------------- stage 2: accumulate ----------------
    logic [SDC_W-1:0] w_sum_dc;
    logic [SC_W-1:0]  w_sum_c;
    logic             w_ovf, w_zero;

    always_comb begin
        w_sum_dc = SDC_W'(r_s1_dc);
        w_sum_c  = SC_W'(r_s1_c);
        if (!r_s1_first) begin
            w_sum_dc = w_sum_dc + r_rd_data[ENT_W-1:SC_W];
            w_sum_c  = w_sum_c + r_rd_data[SC_W-1:0];
        end
        // floor(a/b) >= 2^disp_bits exactly when floor(a/2^disp_bits) >= b
        w_ovf     = (w_sum_dc[SDC_W-1:disp_bits] >= w_sum_c);
        w_zero    = (w_sum_c == '0);
        w_wr_en   = r_s1_valid && !r_s1_last;
        w_wr_data = {w_sum_dc, w_sum_c};
    end

    // Divider pipeline: index 0 is the accumulate register, index gi+1 is the
    // output of divider stage gi.
    logic                 r_valid [0:disp_bits];
    logic [SDC_W-1:0]     r_rem   [0:disp_bits];
    logic [SC_W-1:0]      r_div   [0:disp_bits];
    logic [disp_bits-1:0] r_quo   [0:disp_bits];
    logic [7:0]           r_conf  [0:disp_bits];
    logic                 r_ovf   [0:disp_bits];
    logic                 r_zero  [0:disp_bits];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid[0] <= 1'b0;
            r_rem[0]   <= '0;
            r_div[0]   <= '0;
            r_quo[0]   <= '0;
            r_conf[0]  <= '0;
            r_ovf[0]   <= 1'b0;
            r_zero[0]  <= 1'b0;
        end else begin
            r_valid[0] <= r_s1_valid && r_s1_last;
            r_rem[0]   <= w_sum_dc;
            r_div[0]   <= w_sum_c;
            r_quo[0]   <= '0;
            r_conf[0]  <= w_sum_c[SC_W-1:LOG2_DEC];
            r_ovf[0]   <= w_ovf;
            r_zero[0]  <= w_zero;
        end
    end

    // ---------------- restoring divider, MSB first ----------------
    generate
        for (genvar gi = 0; gi < disp_bits; gi++) begin : g_div_stage
            localparam int J = disp_bits - 1 - gi;
            logic [SDC_W-1:0]     w_shifted;
            logic                 w_ge;
            logic [disp_bits-1:0] w_qbit;

            assign w_shifted = SDC_W'(r_div[gi]) << J;
            assign w_ge      = (r_rem[gi] >= w_shifted);
            assign w_qbit    = disp_bits'(w_ge) << J;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_valid[gi+1] <= 1'b0;
                    r_rem[gi+1]   <= '0;
                    r_div[gi+1]   <= '0;
                    r_quo[gi+1]   <= '0;
                    r_conf[gi+1]  <= '0;
                    r_ovf[gi+1]   <= 1'b0;
                    r_zero[gi+1]  <= 1'b0;
                end else begin
                    r_valid[gi+1] <= r_valid[gi];
                    r_rem[gi+1]   <= w_ge ? (r_rem[gi] - w_shifted) : r_rem[gi];
                    r_div[gi+1]   <= r_div[gi];
                    r_quo[gi+1]   <= r_quo[gi] | w_qbit;
                    r_conf[gi+1]  <= r_conf[gi];
                    r_ovf[gi+1]   <= r_ovf[gi];
                    r_zero[gi+1]  <= r_zero[gi];
                end
            end
        end
    endgenerate

    // ---------------- output register ----------------
    logic                 r_out_valid;
    logic [disp_bits-1:0] r_disp_out;
    logic [7:0]           r_conf_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_disp_out  <= '0;
            r_conf_out  <= '0;
        end else begin
            r_out_valid <= r_valid[disp_bits];
            if (r_valid[disp_bits]) begin
                if (r_zero[disp_bits]) begin
                    r_disp_out <= '0;
                    r_conf_out <= '0;
                end else begin
                    r_disp_out <= r_ovf[disp_bits] ? '1 : r_quo[disp_bits];
                    r_conf_out <= r_conf[disp_bits];
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.disp_out  = r_disp_out;
    assign bus.conf_out  = r_conf_out;
endmodule

// File: tb/tb_disp_vertical_averager.sv
// Directed plus randomized checks of disp_vertical_averager against a
// per-column sum / integer-division reference model.
module tb_disp_vertical_averager;
    localparam int DB  = 5;
    localparam int DEC = 2;
    localparam int W   = 4;
    localparam int LAT = DB + 3;
    localparam int MAXQ = (1 << DB) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    disp_vertical_averager_if #(.disp_bits(DB)) bus();

    disp_vertical_averager #(
        .disp_bits (DB),
        .dec_factor(DEC),
        .out_width (W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int t;
        int disp;
        int conf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_disp = 0;
    int   last_conf = 0;
    int   m_col = 0;
    int   m_row = 0;
    int   m_sdc [W];
    int   m_sc  [W];

    // Reference: sum the column over DEC rows, then integer divide with clamp.
    task automatic send(input bit fs, input bit v, input int dc, input int c);
        int d, cf;
        @(negedge clk);
        bus.frame_start  = fs;
        bus.in_valid     = v;
        bus.disp_conf_in = (DB+8)'(dc);
        bus.conf_in      = 8'(c);
        if (fs) begin
            m_col = 0;
            m_row = 0;
        end
        if (v) begin
            if (m_row == 0) begin
                m_sdc[m_col] = dc;
                m_sc[m_col]  = c;
            end else begin
                m_sdc[m_col] += dc;
                m_sc[m_col]  += c;
            end
            if (m_row == DEC - 1) begin
                if (m_sc[m_col] == 0) begin
                    d  = 0;
                    cf = 0;
                end else begin
                    d  = m_sdc[m_col] / m_sc[m_col];
                    if (d > MAXQ) d = MAXQ;
                    cf = m_sc[m_col] / DEC;
                end
                q.push_back('{cyc + 1 + LAT, d, cf});
            end
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row + 1) % DEC;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, 0, 0);
    endtask

    task automatic rnd_samples(input int n);
        for (int i = 0; i < n; i++)
            send(1'b0, 1'b1, int'($urandom_range(0, 8191)), int'($urandom_range(0, 255)));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        reset = 1'b1;
        q.delete();
        last_disp = 0;
        last_conf = 0;
        m_col = 0;
        m_row = 0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one sample per cycle, 1 time unit after the active edge.
    logic exp_v;
    exp_t e;
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        exp_v = (q.size() > 0) && (q[0].t == cyc);
        if (exp_v) begin
            e = q.pop_front();
            last_disp = e.disp;
            last_conf = e.conf;
        end
        if (bus.out_valid === 1'b1)
            $display("result cyc=%0d disp_out=%0d conf_out=%0d", cyc, bus.disp_out, bus.conf_out);
        checks++;
        assert (bus.out_valid === exp_v) else begin
            errors++;
            $error("FAIL out_valid cyc=%0d observed=%b expected=%b", cyc, bus.out_valid, exp_v);
        end
        checks++;
        assert (bus.disp_out === DB'(last_disp)) else begin
            errors++;
            $error("FAIL disp_out cyc=%0d observed=%0d expected=%0d", cyc, bus.disp_out, last_disp);
        end
        checks++;
        assert (bus.conf_out === 8'(last_conf)) else begin
            errors++;
            $error("FAIL conf_out cyc=%0d observed=%0d expected=%0d", cyc, bus.conf_out, last_conf);
        end
    end

    initial begin
        bus.frame_start  = 1'b0;
        bus.in_valid     = 1'b0;
        bus.disp_conf_in = '0;
        bus.conf_in      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // basic average, then zero confidence on cols 1..3
        send(1'b0, 1'b1, 500, 50);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 0, 0);
        send(1'b0, 1'b1, 1000, 50);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 0, 0);
        idle(3);

        // saturation on col 0: 16382 / 1
        send(1'b0, 1'b1, 8191, 1);
        rnd_samples(3);
        send(1'b0, 1'b1, 8191, 0);
        rnd_samples(3);
        idle(2);

        // streaming: 8 distinct back-to-back samples
        for (int i = 0; i < 8; i++) send(1'b0, 1'b1, 100 * i + 37, 10 + 5 * i);
        idle(4);

        // frame restart at row 1 col 2, then a full pass
        rnd_samples(6);
        send(1'b1, 1'b0, 0, 0);
        rnd_samples(8);
        // frame_start coincident with a sample
        rnd_samples(2);
        send(1'b1, 1'b1, int'($urandom_range(0, 8191)), int'($urandom_range(0, 255)));
        rnd_samples(7);
        idle(3);

        // reset three cycles after a last-row sample
        rnd_samples(8);
        idle(2);
        do_reset(2);
        rnd_samples(8);
        idle(10);

        // randomized traffic with gaps, restarts and frequent small confidences
        for (int i = 0; i < 300; i++) begin
            bit v, fs;
            int c;
            v  = ($urandom_range(0, 3) != 0);
            fs = ($urandom_range(0, 40) == 0);
            c  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            send(fs, v, int'($urandom_range(0, 8191)), c);
        end
        idle(LAT + 4);

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL pending_results observed=%0d expected=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
